// File: rtl/midi_note_parser.sv
// MIDI Note On/Off parser: running status, velocity-0-as-off, realtime/system filtering.
// Emits note events through a one-entry valid/ready slot and tracks an 88-key pressed bitmap.
module midi_note_parser #(
    parameter int          NOTE_LO  = 21,
    parameter int          NUM_KEYS = 88,
    parameter bit          OMNI     = 1'b1,
    parameter logic [3:0]  CHANNEL  = 4'd0
) (
    input  logic                clk_100mhz,
    input  logic                reset,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_on,
    output logic [6:0]          evt_key,
    output logic [6:0]          evt_vel,
    output logic [NUM_KEYS-1:0] keys_down,
    output logic                overflow
);

    typedef enum logic [1:0] {WAIT_STATUS, WAIT_NOTE, WAIT_VEL} state_t;
    typedef enum logic [1:0] {RS_NONE, RS_ON, RS_OFF, RS_IGNORE} run_t;

    state_t              state_q, state_d;
    run_t                run_q, run_d;
    logic [6:0]          note_q, note_d;
    logic                evt_valid_q, evt_valid_d;
    logic                evt_on_q, evt_on_d;
    logic [6:0]          evt_key_q, evt_key_d;
    logic [6:0]          evt_vel_q, evt_vel_d;
    logic [NUM_KEYS-1:0] keys_down_q, keys_down_d;
    logic                overflow_q, overflow_d;

    logic       in_range;
    logic       ch_ok;
    logic       is_on;
    logic [6:0] key_idx;

    assign in_range = (int'(note_q) >= NOTE_LO) && (int'(note_q) < NOTE_LO + NUM_KEYS);
    assign ch_ok    = OMNI || (byte_in[3:0] == CHANNEL);
    assign is_on    = (run_q == RS_ON) && (byte_in[6:0] != 7'd0);
    assign key_idx  = note_q - 7'(NOTE_LO);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        run_d       = run_q;
        note_d      = note_q;
        evt_valid_d = evt_valid_q;
        evt_on_d    = evt_on_q;
        evt_key_d   = evt_key_q;
        evt_vel_d   = evt_vel_q;
        keys_down_d = keys_down_q;
        overflow_d  = overflow_q;

        if (evt_valid_q && evt_ready)
            evt_valid_d = 1'b0;

        if (byte_valid) begin
            if (byte_in >= 8'hF8) begin
                // realtime bytes may interleave anywhere and leave parsing untouched
            end else if (byte_in >= 8'hF0) begin
                run_d   = RS_NONE;
                state_d = WAIT_STATUS;
            end else if (byte_in[7]) begin
                if (byte_in[7:5] == 3'b100 && ch_ok)
                    run_d = byte_in[4] ? RS_ON : RS_OFF;
                else
                    run_d = RS_IGNORE;
                state_d = WAIT_NOTE;
            end else begin
                unique case (state_q)
                    WAIT_STATUS: begin
                        if (run_q != RS_NONE) begin
                            note_d  = byte_in[6:0];
                            state_d = WAIT_VEL;
                        end
                    end
                    WAIT_NOTE: begin
                        note_d  = byte_in[6:0];
                        state_d = WAIT_VEL;
                    end
                    WAIT_VEL: begin
                        state_d = WAIT_NOTE;
                        if ((run_q == RS_ON || run_q == RS_OFF) && in_range) begin
                            keys_down_d[key_idx] = is_on;
                            // slot is free if empty or being drained on this same edge
                            if (!evt_valid_q || evt_ready) begin
                                evt_valid_d = 1'b1;
                                evt_on_d    = is_on;
                                evt_key_d   = key_idx;
                                evt_vel_d   = byte_in[6:0];
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end
                    default: state_d = WAIT_STATUS;
                endcase
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
        if (reset) begin
            state_q     <= WAIT_STATUS;
            run_q       <= RS_NONE;
            note_q      <= '0;
            evt_valid_q <= 1'b0;
            evt_on_q    <= 1'b0;
            evt_key_q   <= '0;
            evt_vel_q   <= '0;
            keys_down_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            note_q      <= note_d;
            evt_valid_q <= evt_valid_d;
            evt_on_q    <= evt_on_d;
            evt_key_q   <= evt_key_d;
            evt_vel_q   <= evt_vel_d;
            keys_down_q <= keys_down_d;
            overflow_q  <= overflow_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_on    = evt_on_q;
    assign evt_key   = evt_key_q;
    assign evt_vel   = evt_vel_q;
    assign keys_down = keys_down_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed bench for midi_note_parser: expected events are queued when a message is sent
// and compared when the consumer accepts them; a second instance covers channel filtering.
module tb_midi_note_parser;

    logic        clk_100mhz = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        evt_valid, evt_ready, evt_on;
    logic [6:0]  evt_key, evt_vel;
    logic [87:0] keys_down;
    logic        overflow;

    logic [7:0]  b2_in;
    logic        b2_valid;
    logic        evt2_valid, evt2_on;
    logic        evt2_ready;
    logic [6:0]  evt2_key, evt2_vel;
    logic [87:0] keys2_down;
    logic        overflow2;

    int          errors = 0;
    int          checks = 0;
    int          ev2_count = 0;
    logic [14:0] exp_q[$];

    always #5 clk_100mhz = ~clk_100mhz;

    midi_note_parser dut (
        .clk_100mhz(clk_100mhz), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_on(evt_on), .evt_key(evt_key),
        .evt_vel(evt_vel), .keys_down(keys_down), .overflow(overflow)
    );

    midi_note_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) dut_ch (
        .clk_100mhz(clk_100mhz), .reset(reset), .byte_in(b2_in), .byte_valid(b2_valid),
        .evt_valid(evt2_valid), .evt_ready(evt2_ready), .evt_on(evt2_on), .evt_key(evt2_key),
        .evt_vel(evt2_vel), .keys_down(keys2_down), .overflow(overflow2)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_100mhz);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        b2_in    = b;
        b2_valid = 1'b1;
        tick();
        b2_valid = 1'b0;
    endtask

    task automatic expect_evt(input logic on, input int key, input logic [6:0] vel);
        exp_q.push_back({on, 7'(key), vel});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        check(tag, 128'(exp_q.size()), 128'd0);
    endtask

    // Scoreboard side: every accepted event must match the oldest queued expectation.
    always @(negedge clk_100mhz) begin
        if (!reset && evt_valid && evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_event observed=%0h expected=none", {evt_on, evt_key, evt_vel});
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                assert ({evt_on, evt_key, evt_vel} === e) else begin
                    errors++;
                    $error("FAIL event observed=%0h expected=%0h", {evt_on, evt_key, evt_vel}, e);
                end
            end
        end
        if (!reset && evt2_valid && evt2_ready)
            ev2_count++;
    end

    initial begin
        reset      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        evt_ready  = 1'b1;
        b2_in      = 8'h00;
        b2_valid   = 1'b0;
        evt2_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        tick();

        check("reset_evt_valid", 128'(evt_valid), 128'd0);
        check("reset_keys_down", 128'(keys_down), 128'd0);
        check("reset_overflow", 128'(overflow), 128'd0);

        // Single note on, latency one cycle after the velocity byte.
        expect_evt(1'b1, 39, 7'h64);
        send(8'h90); send(8'h3C); send(8'h64);
        check("latency_evt_valid", 128'(evt_valid), 128'd1);
        drain("drain_single");
        check("key39_on", 128'(keys_down[39]), 128'd1);

        // Running status, then velocity-0 as note off.
        expect_evt(1'b1, 39, 7'h64);
        expect_evt(1'b1, 41, 7'h50);
        expect_evt(1'b0, 39, 7'h00);
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h3E); send(8'h50);
        send(8'h3C); send(8'h00);
        drain("drain_running");
        check("running_key39", 128'(keys_down[39]), 128'd0);
        check("running_key41", 128'(keys_down[41]), 128'd1);

        // Realtime bytes interleaved, then an out-of-range note.
        expect_evt(1'b1, 39, 7'h64);
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
        drain("drain_realtime");
        send(8'h90); send(8'h10); send(8'h64);
        tick(3);
        check("low_note_no_event", 128'(evt_valid), 128'd0);

        // Range edges: note 21 -> key 0, note 108 -> key 87, note 109 ignored.
        expect_evt(1'b1, 0, 7'h01);
        expect_evt(1'b1, 87, 7'h01);
        send(8'h90); send(8'h15); send(8'h01);
        send(8'h6C); send(8'h01);
        send(8'h6D); send(8'h01);
        drain("drain_edges");
        check("edge_keys", {keys_down[87], keys_down[0]}, 128'd3);
        check("note109_no_event", 128'(evt_valid), 128'd0);

        // Full slot: second completion is dropped but still updates the bitmap.
        evt_ready = 1'b0;
        expect_evt(1'b1, 39, 7'h64);
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h80); send(8'h3C); send(8'h40);
        tick();
        check("ovf_flag", 128'(overflow), 128'd1);
        check("ovf_key39_off", 128'(keys_down[39]), 128'd0);
        check("ovf_held_evt", {evt_valid, evt_on, evt_key, evt_vel}, {1'b1, 1'b1, 7'd39, 7'h64});
        evt_ready = 1'b1;
        drain("drain_ovf");
        check("ovf_evt_valid_falls", 128'(evt_valid), 128'd0);
        check("ovf_sticky", 128'(overflow), 128'd1);

        // Channel filter on the OMNI=0, CHANNEL=2 instance.
        send2(8'h91); send2(8'h3C); send2(8'h64);
        tick(2);
        check("ch1_rejected", 128'(ev2_count), 128'd0);
        send2(8'h92); send2(8'h3C); send2(8'h64);
        check("ch2_evt", {evt2_valid, evt2_on, evt2_key, evt2_vel}, {1'b1, 1'b1, 7'd39, 7'h64});
        tick(2);
        check("ch2_count", 128'(ev2_count), 128'd1);
        send2(8'hF0); send2(8'h3C); send2(8'h64);
        tick(2);
        check("sysex_clears_running", 128'(ev2_count), 128'd1);

        // Reset mid-message abandons the partial note and clears everything.
        send(8'h90); send(8'h3C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send(8'h64);
        tick(2);
        check("post_reset_no_event", 128'(evt_valid), 128'd0);
        check("post_reset_keys", 128'(keys_down), 128'd0);
        check("post_reset_overflow", 128'(overflow), 128'd0);
        check("queue_empty_end", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
